mult_seq_digit: RTL



---
 rtl/mult_seq_digit.sv | 101 ++++++++++
 1 files changed

// File: rtl/mult_seq_digit.sv
// Sequential unsigned WIDTH x WIDTH multiplier that accumulates one 2x2 digit product per clock.
// Optional MULT_SEQ_ZERO_SKIP_EN: a zero operand goes straight to DONE with product 0.
module mult_seq_digit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned D     = WIDTH / 2;
    localparam int unsigned NPAIR = D * D;
    localparam int unsigned CW    = (NPAIR > 1) ? $clog2(NPAIR) : 1;
    localparam logic [CW-1:0] LAST = CW'(NPAIR - 1);
    localparam logic [CW-1:0] DL   = CW'(D);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state, state_nx;
    logic [WIDTH-1:0]     a_q, b_q;
    logic [2*WIDTH-1:0]   acc;
    logic [CW-1:0]        cnt;

    logic [CW-1:0]        di, dj;
    logic [WIDTH-1:0]     a_sh, b_sh;
    logic [1:0]           da, db;
    logic [3:0]           pp;
    logic [2*WIDTH-1:0]   term;
    logic [2*WIDTH-1:0]   acc_nx;
    logic                 accept, zero_op;

    // digit select and 2x2 product stage; pp is consumed in the same cycle
    always_comb begin
        di     = cnt / DL;
        dj     = cnt % DL;
        a_sh   = a_q >> {di, 1'b0};
        b_sh   = b_q >> {dj, 1'b0};
        da     = a_sh[1:0];
        db     = b_sh[1:0];
        pp     = {2'b00, da} * {2'b00, db};
        term   = (2*WIDTH)'(pp) << {(di + dj), 1'b0};
        acc_nx = acc + term;
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        accept    = in_valid && in_ready;
`ifdef MULT_SEQ_ZERO_SKIP_EN
        zero_op   = (a == '0) || (b == '0);
`else
        zero_op   = 1'b0;
`endif
        state_nx  = state;
        case (state)
            IDLE: if (accept) state_nx = zero_op ? DONE : RUN;
            RUN:  if (cnt == LAST) state_nx = DONE;
            DONE: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (accept) begin
                    a_q <= a;
                    b_q <= b;
                    acc <= '0;
                    cnt <= '0;
                    if (zero_op) product <= '0;
                end
                RUN: begin
                    acc <= acc_nx;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) product <= acc_nx;
                end
                default: ;
            endcase
        end
    end

endmodule
